// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one fixed-latency memory between fetch and data stages, data first, fetch never starved
module mem_arbiter #(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 32,
  parameter int MEM_LATENCY = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  if_req,
  input  logic [ADDR_WIDTH-1:0] if_addr,
  output logic [DATA_WIDTH-1:0] if_rdata,
  output logic                  if_ack,
  input  logic                  dm_req,
  input  logic                  dm_we,
  input  logic                  dm_byte,
  input  logic [ADDR_WIDTH-1:0] dm_addr,
  input  logic [DATA_WIDTH-1:0] dm_wdata,
  output logic [DATA_WIDTH-1:0] dm_rdata,
  output logic                  dm_ack,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic                  mem_byte,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} stateT;
  localparam logic [3:0] LAT = 4'(MEM_LATENCY);
  stateT state, nextState;
  logic [3:0] cnt;
  logic ownerData, weQ, dmGo, ifGo, done;
  always_ff @(posedge clk)
    state <= rst ? IDLE : nextState;
  // a port acking this cycle is masked, so a busy data port alternates with fetch
  always_comb begin
    dmGo = state == IDLE && dm_req && !dm_ack;
    ifGo = state == IDLE && if_req && !if_ack && !dmGo;
    done = state == WAIT && cnt == LAT;
    nextState = state == IDLE ? (dmGo || ifGo ? ISSUE : IDLE) :
                state == ISSUE ? WAIT : done ? IDLE : WAIT;
  end
  always_comb begin
    mem_en = state == ISSUE;
    mem_we = mem_en && ownerData && weQ;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt       <= '0;
      ownerData <= 1'b0;
      weQ       <= 1'b0;
      mem_byte  <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      if_ack    <= 1'b0;
      dm_ack    <= 1'b0;
      if_rdata  <= '0;
      dm_rdata  <= '0;
    end else begin
      cnt <= state == ISSUE ? 4'd1 : state == WAIT ? cnt + 4'd1 : cnt;
      if (dmGo || ifGo) begin
        ownerData <= dmGo;
        weQ       <= dmGo && dm_we;
        mem_byte  <= dmGo && dm_byte;
        mem_addr  <= dmGo ? dm_addr : if_addr;
        mem_wdata <= dmGo ? dm_wdata : '0;
      end
      if_ack <= done && !ownerData;
      dm_ack <= done && ownerData;
      if (done && !ownerData) if_rdata <= mem_rdata;
      if (done && ownerData && !weQ) dm_rdata <= mem_rdata;
    end
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed checks of reset, priority, fetch, store, fairness and mid-access reset
module tb_mem_arbiter;
  localparam int L = 2;
  logic clk = 1'b0, rst = 1'b1;
  logic if_req = 1'b0, dm_req = 1'b0, dm_we = 1'b0, dm_byte = 1'b0;
  logic [31:0] if_addr = '0, dm_addr = '0, dm_wdata = '0;
  logic [31:0] if_rdata, dm_rdata, mem_addr, mem_wdata, mem_rdata;
  logic if_ack, dm_ack, mem_en, mem_we, mem_byte;
  logic [L-1:0] pv = '0;
  logic [31:0] pd [L];
  int nCmp = 0, nBad = 0, acks = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .MEM_LATENCY(L)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
    .dm_req(dm_req), .dm_we(dm_we), .dm_byte(dm_byte), .dm_addr(dm_addr),
    .dm_wdata(dm_wdata), .dm_rdata(dm_rdata), .dm_ack(dm_ack),
    .mem_en(mem_en), .mem_we(mem_we), .mem_byte(mem_byte), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  // memory model: data appears exactly L cycles after the issue cycle
  always @(posedge clk) begin
    pv[0] <= mem_en;
    pd[0] <= mem_addr == 32'h10 ? 32'hDEADBEEF : (32'hC0DE0000 | mem_addr);
    for (int i = 1; i < L; i++) begin
      pv[i] <= pv[i-1];
      pd[i] <= pd[i-1];
    end
  end
  assign mem_rdata = pv[L-1] ? pd[L-1] : 32'hBAD0BAD0;

  task automatic chk(input string tag, input logic [95:0] got, input logic [95:0] exp);
    nCmp++;
    if (got !== exp) begin
      nBad++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  task automatic cyc;
    @(negedge clk);
  endtask

  initial begin
    if_req = 1'b1; dm_req = 1'b1; dm_addr = 32'h40; if_addr = 32'h30;
    repeat (2) begin
      cyc;
      chk("rst_ctl", {mem_en, mem_we, mem_byte, if_ack, dm_ack}, 0);
      chk("rst_bus", {mem_addr, mem_wdata}, 0);
      chk("rst_rd", {if_rdata, dm_rdata}, 0);
    end
    rst = 1'b0;
    cyc;
    chk("pri_issue_d", {mem_en, mem_we, mem_addr}, {2'b10, 32'h40});
    repeat (3) cyc;
    chk("pri_dm_ack", {dm_ack, if_ack}, 2'b10);
    chk("pri_dm_rdata", dm_rdata, 32'hC0DE0040);
    dm_req = 1'b0;
    cyc;
    chk("pri_issue_f", {mem_en, mem_we, mem_byte, mem_addr}, {3'b100, 32'h30});
    repeat (3) cyc;
    chk("pri_if_ack", {dm_ack, if_ack}, 2'b01);
    chk("pri_if_rdata", if_rdata, 32'hC0DE0030);
    if_req = 1'b0;
    cyc;
    chk("pri_ack_drop", {dm_ack, if_ack, mem_en}, 0);
    if_req = 1'b1; if_addr = 32'h10;
    cyc;
    chk("f_issue", {mem_en, mem_addr}, {1'b1, 32'h10});
    cyc;
    chk("f_en_pulse", mem_en, 0);
    repeat (2) cyc;
    chk("f_ack", {if_ack, if_rdata}, {1'b1, 32'hDEADBEEF});
    chk("f_dm_hold", dm_rdata, 32'hC0DE0040);
    if_req = 1'b0;
    cyc;
    chk("f_ack_pulse", {if_ack, mem_en}, 0);
    dm_req = 1'b1; dm_we = 1'b1; dm_byte = 1'b1; dm_addr = 32'h100; dm_wdata = 32'h12345678;
    cyc;
    chk("st_issue", {mem_en, mem_we, mem_byte, mem_addr, mem_wdata}, {3'b111, 32'h100, 32'h12345678});
    dm_addr = 32'h200; dm_wdata = 32'h0;
    cyc;
    chk("st_we_pulse", {mem_en, mem_we}, 0);
    cyc;
    chk("st_latched", {mem_byte, mem_addr, mem_wdata}, {1'b1, 32'h100, 32'h12345678});
    cyc;
    chk("st_ack", {dm_ack, dm_rdata}, {1'b1, 32'hC0DE0040});
    dm_req = 1'b0; dm_we = 1'b0; dm_byte = 1'b0;
    cyc;
    chk("st_ack_pulse", {dm_ack, mem_en}, 0);
    dm_req = 1'b1; if_req = 1'b1; dm_addr = 32'h50; if_addr = 32'h60;
    for (int c = 1; c <= 40; c++) begin
      cyc;
      chk($sformatf("fair_c%0d", c), {mem_en, dm_ack, if_ack}, {c % 4 == 1, c % 8 == 4, c % 8 == 0});
      if (c % 4 == 1) chk($sformatf("fair_addr_c%0d", c), mem_addr, c % 8 == 1 ? 32'h50 : 32'h60);
      acks += dm_ack + if_ack;
    end
    chk("fair_acks", acks, 10);
    dm_req = 1'b0; if_req = 1'b0;
    cyc;
    chk("fair_idle", mem_en, 0);
    if_req = 1'b1; if_addr = 32'h70;
    cyc;
    chk("ra_issue", {mem_en, mem_addr}, {1'b1, 32'h70});
    cyc;
    rst = 1'b1; if_req = 1'b0;
    cyc;
    chk("ra_rst_ctl", {mem_en, mem_we, mem_byte, if_ack, dm_ack}, 0);
    chk("ra_rst_bus", {mem_addr, mem_wdata}, 0);
    chk("ra_rst_rd", {if_rdata, dm_rdata}, 0);
    rst = 1'b0;
    cyc;
    chk("ra_no_ack", {if_ack, dm_ack, mem_en}, 0);
    if_req = 1'b1; if_addr = 32'h20;
    cyc;
    chk("ra_new_issue", {mem_en, mem_addr}, {1'b1, 32'h20});
    repeat (3) cyc;
    chk("ra_new_ack", {if_ack, if_rdata}, {1'b1, 32'hC0DE0020});
    if_req = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port arbiter and sequencer placing the instruction-fetch stage and the data-memory stage of the pipelined CPU on one shared single-ported unified memory with fixed read latency. It accepts level-held requests from both stages, grants one at a time (data first, fetch never starved), drives the memory with single-cycle issue pulses, counts out the memory latency, and returns read data with a one-cycle acknowledge. The pipeline treats a pending request without `ack` as a stall.

## Interface
- `DATA_WIDTH`, 32, memory data width.
- `ADDR_WIDTH`, 32, byte-address width.
- `MEM_LATENCY`, 2, cycles from the issue cycle to valid `mem_rdata`; legal range 1–15.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  reset, synchronous and active-high.
- `if_req`  in  1  fetch request, held until `if_ack`.
- `if_addr`  in  ADDR_WIDTH  fetch address.
- `if_rdata`  out  DATA_WIDTH  fetched word, valid while `if_ack`=1 and held until the next fetch ack.
- `if_ack`  out  1  one-cycle fetch completion pulse.
- `dm_req`  in  1  data request, held until `dm_ack`.
- `dm_we`  in  1  1 = store, 0 = load.
- `dm_byte`  in  1  byte-sized access (ByteOp).
- `dm_addr`  in  ADDR_WIDTH  data address.
- `dm_wdata`  in  DATA_WIDTH  store data.
- `dm_rdata`  out  DATA_WIDTH  load data, valid while `dm_ack`=1 and held until the next load ack.
- `dm_ack`  out  1  one-cycle data completion pulse (loads and stores).
- `mem_en`  out  1  one-cycle access issue strobe.
- `mem_we`  out  1  write strobe, only coincident with `mem_en`.
- `mem_byte`  out  1  byte-size qualifier.
- `mem_addr`  out  ADDR_WIDTH  access address.
- `mem_wdata`  out  DATA_WIDTH  store data.
- `mem_rdata`  in  DATA_WIDTH  read data, valid exactly MEM_LATENCY cycles after the `mem_en` cycle.

## Operation
- FSM states: IDLE, ISSUE, WAIT.
- IDLE: sample requests. A port whose ack is high this cycle is masked. If `dm_req` (unmasked) → grant data. Else if `if_req` (unmasked) → grant fetch. Else stay in IDLE.
- On grant: register address, wdata, we, and byte. Set the owner flag. Go to ISSUE.
- ISSUE (one cycle): `mem_en`=1, `mem_we`=owner-is-data & we, latched `mem_addr`/`mem_wdata`/`mem_byte`. Latency counter ← 1. Go to WAIT.
- WAIT: increment the counter each cycle. In the cycle where the counter equals MEM_LATENCY:
  - capture `mem_rdata` into the owner's rdata register (loads and fetches only; stores leave `dm_rdata` unchanged);
  - set the owner's ack for the next cycle;
  - go to IDLE.
- The ack-cycle mask means a continuously requesting data port alternates with a pending fetch. Grants run D, F, D, F…, so fetch cannot starve.
- `mem_addr`, `mem_wdata`, and `mem_byte` hold their latched values from ISSUE until the next grant.
- Fetch requests ignore `dm_we` and `dm_byte`. A fetch is always a word read, with `mem_byte`=0.
- Counter width is 4 bits. MEM_LATENCY outside 1–15 is a configuration error.

## Timing
- Request sampled in IDLE at cycle 0 → ISSUE at cycle 1 → `mem_rdata` valid at cycle 1+L → ack and rdata at cycle 2+L (L = MEM_LATENCY).
- Service interval: one access per L+2 cycles.
  - The next grant can be taken in the ack cycle, for the other port only.
  - The same port can be re-granted at the earliest in the cycle after its ack.
- Simultaneous `if_req` and `dm_req` in IDLE → data granted. Fetch is granted in the data ack cycle if still requested.
- Request inputs are only sampled in IDLE. Changes during ISSUE/WAIT are ignored, and the latched values are used.
- Dropping `req` before ack does not cancel the access. The ack is still produced.
- Reset values: state IDLE, counter 0, owner flag 0, every output 0 (`mem_en`, `mem_we`, `mem_byte`, `mem_addr`, `mem_wdata`, `if_ack`, `dm_ack`, `if_rdata`, `dm_rdata`).
- `rst` in any state (including ISSUE/WAIT) aborts the access. No ack is produced. Outputs are 0 in the cycle after the reset edge. The first post-reset request is serviced normally.

## Test plan
- Reset: `rst`=1 for 2 cycles with both reqs high. Required: all outputs 0 and no `mem_en` during reset; data is granted on the first post-reset cycle.
- Single fetch, L=2: `if_req`, `if_addr`=0x10 at cycle 0. Required: `mem_en`=1 and `mem_addr`=0x10 in cycle 1 only. Model drives 0xDEADBEEF at cycle 3. Required: `if_ack`=1 with `if_rdata`=0xDEADBEEF in cycle 4; `if_ack`=0 in cycle 5.
- Priority, L=2: `if_req` and a `dm_req` load both high at cycle 0. Required: `dm_ack` at cycle 4; fetch granted in cycle 4 with `mem_en` in cycle 5; `if_ack` at cycle 8.
- Store: `dm_we`=1, `dm_byte`=1, `dm_addr`=0x100, `dm_wdata`=0x12345678. Required: in cycle 1 `mem_en`=`mem_we`=`mem_byte`=1 with that address and data; `dm_ack` in cycle 4; `dm_rdata` unchanged from its prior value.
- Fairness: both reqs held high for 40 cycles, L=2. Required: grants alternate D, F, D, F; exactly one ack per 4 cycles.
- Reset mid-access: `rst` pulsed in WAIT (cycle 2). Required: no ack in cycle 4; a new fetch at 0x20 after reset completes with the correct data at L+2 cycles.
